// File: rtl/ysyx_22040759_dcache_axi_bridge_pkg.sv
// Shared types and constants for the dcache-to-AXI bridge.
// FSM encoding, AXI field constants and default widths.
package ysyx_22040759_axi_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_RD_ADDR = 6'b000010,
    S_RD_DATA = 6'b000100,
    S_WR_REQ  = 6'b001000,
    S_WR_RESP = 6'b010000,
    S_DONE    = 6'b100000
  } state_e;

  function automatic logic resp_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_22040759_dcache_axi_bridge_if.sv
// AXI4 master-side bundle between the bridge and the SoC arbiter.
// Single-beat only; bridge uses master, memory side uses slave.
interface ysyx_22040759_dcache_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              axi_awvalid;
  logic              axi_awready;
  logic [ADDR_W-1:0] axi_awaddr;
  logic [ID_W-1:0]   axi_awid;
  logic [7:0]        axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;

  logic              axi_wvalid;
  logic              axi_wready;
  logic [DATA_W-1:0] axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic              axi_wlast;

  logic              axi_bvalid;
  logic              axi_bready;
  logic [1:0]        axi_bresp;
  logic [ID_W-1:0]   axi_bid;

  logic              axi_arvalid;
  logic              axi_arready;
  logic [ADDR_W-1:0] axi_araddr;
  logic [ID_W-1:0]   axi_arid;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;

  logic              axi_rvalid;
  logic              axi_rready;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast;
  logic [ID_W-1:0]   axi_rid;

  modport master (
    output axi_awvalid, axi_awaddr, axi_awid,
    output axi_awlen, axi_awsize, axi_awburst,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_wready,
    input  axi_bvalid, axi_bresp, axi_bid,
    output axi_bready,
    output axi_arvalid, axi_araddr, axi_arid,
    output axi_arlen, axi_arsize, axi_arburst,
    input  axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp,
    input  axi_rlast, axi_rid,
    output axi_rready
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awid,
    input  axi_awlen, axi_awsize, axi_awburst,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_wready,
    output axi_bvalid, axi_bresp, axi_bid,
    input  axi_bready,
    input  axi_arvalid, axi_araddr, axi_arid,
    input  axi_arlen, axi_arsize, axi_arburst,
    output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp,
    output axi_rlast, axi_rid,
    input  axi_rready
  );

endinterface

// File: rtl/ysyx_22040759_dcache_axi_bridge_strb.sv
// Write strobe from access size and byte offset.
// Offset is never realigned; bits shifted past lane 7 are dropped.
module ysyx_22040759_axi_strb (
  input  logic [2:0] size,
  input  logic [2:0] offset,
  output logic [7:0] strb
);

  logic [7:0] base;

  // Base mask by size, then shift into place within 8 bits.
  always_comb begin
    base = 8'h00;
    strb = 8'h00;
    unique case (size)
      3'd0: base = 8'h01;
      3'd1: base = 8'h03;
      3'd2: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    if (size >= 3'd3) strb = 8'hFF;
    else              strb = base << offset;
  end

endmodule

// File: rtl/ysyx_22040759_dcache_axi_bridge.sv
// dcache memory port to single-beat AXI4 bridge.
// One outstanding transaction; completion is a one-cycle ready pulse.
module ysyx_22040759_dcache_axi_bridge
  import ysyx_22040759_axi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcache_ram_valid,
  input  logic              dcache_ram_req,
  input  logic [ADDR_W-1:0] dcache_ram_addr,
  input  logic [DATA_W-1:0] dcache_ram_data_write,
  input  logic [2:0]        dcache_ram_size,
  output logic              ram_dcache_ready,
  output logic [DATA_W-1:0] ram_dcache_data_read,
  output logic              ram_dcache_err,
  ysyx_22040759_dcache_axi_bridge_if.master axi
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        size_q;
  logic              aw_done_q, w_done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic arvalid, rready, awvalid, wvalid, bready;
  logic done, aw_hs, w_hs, r_hs, b_hs;
  logic [7:0] strb;

  // Single-outstanding: response IDs and rlast carry no information.
  logic unused_axi;
  assign unused_axi = ^{axi.axi_rlast, axi.axi_rid, axi.axi_bid};

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and Moore-style channel valids/readies.
  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    done    = 1'b0;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dcache_ram_valid)
          state_d = dcache_ram_req ? S_WR_REQ : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (axi.axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (axi.axi_rvalid) state_d = S_DONE;
      end
      S_WR_REQ: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        aw_hs   = awvalid & axi.axi_awready;
        w_hs    = wvalid & axi.axi_wready;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (axi.axi_bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign r_hs = rready & axi.axi_rvalid;
  assign b_hs = bready & axi.axi_bvalid;

  // Request capture, only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else if (state_q == S_IDLE && dcache_ram_valid) begin
      addr_q  <= dcache_ram_addr;
      wdata_q <= dcache_ram_data_write;
      size_q  <= dcache_ram_size;
    end
  end

  // Per-channel write handshake tracking, cleared each new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
    end
  end

  // Read data held from R handshake until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (r_hs) rdata_q <= axi.axi_rdata;
  end

  // Error flag from whichever response ended the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err_q <= 1'b0;
    else if (r_hs) err_q <= resp_err(axi.axi_rresp);
    else if (b_hs) err_q <= resp_err(axi.axi_bresp);
  end

  ysyx_22040759_axi_strb u_strb (
    .size   (size_q),
    .offset (addr_q[2:0]),
    .strb   (strb)
  );

  assign ram_dcache_ready     = done;
  assign ram_dcache_data_read = rdata_q;
  assign ram_dcache_err       = done & err_q;

  assign axi.axi_arvalid = arvalid;
  assign axi.axi_araddr  = addr_q;
  assign axi.axi_arid    = AXI_ID;
  assign axi.axi_arlen   = 8'd0;
  assign axi.axi_arsize  = size_q;
  assign axi.axi_arburst = AXI_BURST_INCR;
  assign axi.axi_rready  = rready;

  assign axi.axi_awvalid = awvalid;
  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_awid    = AXI_ID;
  assign axi.axi_awlen   = 8'd0;
  assign axi.axi_awsize  = size_q;
  assign axi.axi_awburst = AXI_BURST_INCR;

  assign axi.axi_wvalid  = wvalid;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = strb;
  assign axi.axi_wlast   = 1'b1;
  assign axi.axi_bready  = bready;

endmodule

// File: tb/tb_ysyx_22040759_dcache_axi_bridge.sv
// Directed bench for the dcache AXI bridge.
// Bench acts as dcache and as AXI slave, stepping cycle by cycle.
module tb_ysyx_22040759_dcache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, req;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [2:0]  size;
  logic        ready, err;
  logic [63:0] rdata_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22040759_dcache_axi_bridge_if #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4)
  ) axi ();

  ysyx_22040759_dcache_axi_bridge #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .AXI_ID(4'd0)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dcache_ram_valid      (valid),
    .dcache_ram_req        (req),
    .dcache_ram_addr       (addr),
    .dcache_ram_data_write (wdata),
    .dcache_ram_size       (size),
    .ram_dcache_ready      (ready),
    .ram_dcache_data_read  (rdata_out),
    .ram_dcache_err        (err),
    .axi                   (axi)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    req   = 1'b0;
    addr  = '0;
    wdata = '0;
    size  = '0;
    axi.axi_awready = 1'b0;
    axi.axi_wready  = 1'b0;
    axi.axi_bvalid  = 1'b0;
    axi.axi_bresp   = 2'b00;
    axi.axi_bid     = '0;
    axi.axi_arready = 1'b0;
    axi.axi_rvalid  = 1'b0;
    axi.axi_rdata   = '0;
    axi.axi_rresp   = 2'b00;
    axi.axi_rlast   = 1'b1;
    axi.axi_rid     = '0;

    step(); step();
    chk("rst_arvalid", axi.axi_arvalid, 0);
    chk("rst_awvalid", axi.axi_awvalid, 0);
    chk("rst_wvalid", axi.axi_wvalid, 0);
    chk("rst_bready", axi.axi_bready, 0);
    chk("rst_rready", axi.axi_rready, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata_out, 0);
    rst = 1'b0;
    step();

    // Read, zero-wait slave
    valid = 1; req = 0; addr = 32'h8000_0100; size = 3;
    axi.axi_arready = 1;
    chk("t1_c0_arvalid", axi.axi_arvalid, 0);
    step();
    chk("t1_c1_arvalid", axi.axi_arvalid, 1);
    chk("t1_araddr", axi.axi_araddr, 64'h8000_0100);
    chk("t1_arsize", axi.axi_arsize, 3);
    chk("t1_arlen", axi.axi_arlen, 0);
    chk("t1_arburst", axi.axi_arburst, 1);
    chk("t1_arid", axi.axi_arid, 0);
    chk("t1_c1_ready", ready, 0);
    step();
    chk("t1_c2_rready", axi.axi_rready, 1);
    chk("t1_c2_arvalid", axi.axi_arvalid, 0);
    axi.axi_rvalid = 1;
    axi.axi_rdata  = 64'h1122_3344_5566_7788;
    axi.axi_rresp  = 2'b00;
    axi.axi_arready = 0;
    step();
    chk("t1_c3_ready", ready, 1);
    chk("t1_c3_data", rdata_out, 64'h1122_3344_5566_7788);
    chk("t1_c3_err", err, 0);
    chk("t1_c3_rready", axi.axi_rready, 0);
    valid = 0;
    axi.axi_rvalid = 0;
    step();
    chk("t1_c4_ready", ready, 0);

    // Write byte at offset 5
    valid = 1; req = 1; addr = 32'h8000_0105; size = 0;
    wdata = 64'h0000_AB00_0000_0000;
    axi.axi_awready = 1;
    axi.axi_wready  = 1;
    step();
    chk("t2_awvalid", axi.axi_awvalid, 1);
    chk("t2_wvalid", axi.axi_wvalid, 1);
    chk("t2_wstrb", axi.axi_wstrb, 8'h20);
    chk("t2_awsize", axi.axi_awsize, 0);
    chk("t2_awaddr", axi.axi_awaddr, 64'h8000_0105);
    chk("t2_wdata", axi.axi_wdata, 64'h0000_AB00_0000_0000);
    chk("t2_wlast", axi.axi_wlast, 1);
    chk("t2_awlen", axi.axi_awlen, 0);
    chk("t2_awburst", axi.axi_awburst, 1);
    chk("t2_c1_bready", axi.axi_bready, 0);
    step();
    chk("t2_c2_awvalid", axi.axi_awvalid, 0);
    chk("t2_c2_wvalid", axi.axi_wvalid, 0);
    chk("t2_c2_bready", axi.axi_bready, 1);
    chk("t2_c2_ready", ready, 0);
    axi.axi_bvalid = 1;
    axi.axi_bresp  = 2'b00;
    step();
    chk("t2_c3_ready", ready, 1);
    chk("t2_c3_err", err, 0);
    chk("t2_c3_bready", axi.axi_bready, 0);
    valid = 0;
    axi.axi_bvalid  = 0;
    axi.axi_awready = 0;
    axi.axi_wready  = 0;
    step();
    chk("t2_c4_ready", ready, 0);

    // AW ready late, W ready at once
    valid = 1; req = 1; addr = 32'h8000_0200; size = 3;
    wdata = 64'h0102_0304_0506_0708;
    axi.axi_wready = 1;
    step();
    chk("t3_c1_awvalid", axi.axi_awvalid, 1);
    chk("t3_c1_wvalid", axi.axi_wvalid, 1);
    chk("t3_wstrb", axi.axi_wstrb, 8'hFF);
    step();
    chk("t3_c2_wvalid", axi.axi_wvalid, 0);
    chk("t3_c2_awvalid", axi.axi_awvalid, 1);
    chk("t3_c2_bready", axi.axi_bready, 0);
    axi.axi_wready = 0;
    step();
    chk("t3_c3_awvalid", axi.axi_awvalid, 1);
    chk("t3_c3_wvalid", axi.axi_wvalid, 0);
    chk("t3_c3_bready", axi.axi_bready, 0);
    chk("t3_c3_ready", ready, 0);
    step();
    chk("t3_c4_awvalid", axi.axi_awvalid, 1);
    chk("t3_c4_bready", axi.axi_bready, 0);
    axi.axi_awready = 1;
    step();
    chk("t3_c5_awvalid", axi.axi_awvalid, 0);
    chk("t3_c5_bready", axi.axi_bready, 1);
    chk("t3_c5_ready", ready, 0);
    axi.axi_awready = 0;
    axi.axi_bvalid  = 1;
    step();
    chk("t3_c6_ready", ready, 1);
    valid = 0;
    axi.axi_bvalid = 0;
    step();
    chk("t3_c7_ready", ready, 0);

    // Back-to-back write then read, valid held
    valid = 1; req = 1; addr = 32'h8000_0300; size = 2;
    wdata = 64'h0000_0000_DEAD_BEEF;
    axi.axi_awready = 1;
    axi.axi_wready  = 1;
    axi.axi_arready = 1;
    step();
    chk("t4_c1_awvalid", axi.axi_awvalid, 1);
    chk("t4_wstrb", axi.axi_wstrb, 8'h0F);
    step();
    chk("t4_c2_bready", axi.axi_bready, 1);
    axi.axi_bvalid = 1;
    step();
    chk("t4_c3_ready", ready, 1);
    req = 0; addr = 32'h8000_0308; size = 3;
    axi.axi_bvalid = 0;
    step();
    chk("t4_c4_ready", ready, 0);
    chk("t4_c4_arvalid", axi.axi_arvalid, 0);
    chk("t4_c4_data", rdata_out, 64'h1122_3344_5566_7788);
    step();
    chk("t4_c5_arvalid", axi.axi_arvalid, 1);
    chk("t4_c5_araddr", axi.axi_araddr, 64'h8000_0308);
    chk("t4_c5_data", rdata_out, 64'h1122_3344_5566_7788);
    step();
    chk("t4_c6_rready", axi.axi_rready, 1);
    chk("t4_c6_data", rdata_out, 64'h1122_3344_5566_7788);
    axi.axi_rvalid = 1;
    axi.axi_rdata  = 64'hCAFE_F00D_1234_5678;
    step();
    chk("t4_c7_ready", ready, 1);
    chk("t4_c7_data", rdata_out, 64'hCAFE_F00D_1234_5678);
    valid = 0;
    axi.axi_rvalid  = 0;
    axi.axi_awready = 0;
    axi.axi_wready  = 0;
    step();
    chk("t4_c8_ready", ready, 0);

    // SLVERR read, then OKAY read
    valid = 1; req = 0; addr = 32'h8000_0400;
    step();
    chk("t5_c1_arvalid", axi.axi_arvalid, 1);
    step();
    axi.axi_rvalid = 1;
    axi.axi_rresp  = 2'b10;
    axi.axi_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    chk("t5_c3_ready", ready, 1);
    chk("t5_c3_err", err, 1);
    valid = 0;
    axi.axi_rvalid = 0;
    axi.axi_rresp  = 2'b00;
    step();
    chk("t5_c4_ready", ready, 0);
    chk("t5_c4_err", err, 0);
    valid = 1; addr = 32'h8000_0408;
    step(); step();
    axi.axi_rvalid = 1;
    axi.axi_rdata  = 64'h5555_AAAA_5555_AAAA;
    step();
    chk("t5b_ready", ready, 1);
    chk("t5b_err", err, 0);
    chk("t5b_data", rdata_out, 64'h5555_AAAA_5555_AAAA);
    valid = 0;
    axi.axi_rvalid = 0;
    step();

    // Reset while waiting in RD_DATA
    valid = 1; req = 0; addr = 32'h8000_0500;
    step();
    chk("t6_c1_arvalid", axi.axi_arvalid, 1);
    step();
    chk("t6_c2_rready", axi.axi_rready, 1);
    #2;
    rst = 1;
    #1;
    chk("t6_rst_rready", axi.axi_rready, 0);
    chk("t6_rst_arvalid", axi.axi_arvalid, 0);
    chk("t6_rst_awvalid", axi.axi_awvalid, 0);
    chk("t6_rst_wvalid", axi.axi_wvalid, 0);
    chk("t6_rst_bready", axi.axi_bready, 0);
    chk("t6_rst_ready", ready, 0);
    chk("t6_rst_data", rdata_out, 0);
    valid = 0;
    step();
    step();
    rst = 0;
    step();
    chk("t6_post_ready", ready, 0);
    chk("t6_post_arvalid", axi.axi_arvalid, 0);
    valid = 1; addr = 32'h8000_0600;
    step();
    chk("t6n_arvalid", axi.axi_arvalid, 1);
    chk("t6n_araddr", axi.axi_araddr, 64'h8000_0600);
    step();
    axi.axi_rvalid = 1;
    axi.axi_rdata  = 64'h7777_6666_5555_4444;
    step();
    chk("t6n_ready", ready, 1);
    chk("t6n_data", rdata_out, 64'h7777_6666_5555_4444);
    valid = 0;
    axi.axi_rvalid = 0;
    step();
    chk("t6n_c4_ready", ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
